// File: rtl/coproc_axi_master.sv
`default_nettype none
// ============================================================================
// coproc_axi_master : AXI4-Lite initiator that writes NUM1/NUM2/INSTR, polls
//                     STATUS until ready, then reads RESULT for the host.
// Rev 1.0
// ============================================================================
module coproc_axi_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_MAX  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] num1_in,
  input  logic [31:0] num2_in,
  input  logic [1:0]  op_in,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] result_out,
  output logic [31:0] axi_awaddr,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [31:0] axi_wdata,
  output logic        axi_wvalid,
  input  logic        axi_wready,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [31:0] axi_araddr,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [31:0] axi_rdata,
  input  logic        axi_rvalid,
  output logic        axi_rready
);

  localparam logic [31:0] C_OFF_NUM1   = 32'h0000_0000;
  localparam logic [31:0] C_OFF_NUM2   = 32'h0000_0004;
  localparam logic [31:0] C_OFF_INSTR  = 32'h0000_0008;
  localparam logic [31:0] C_OFF_RESULT = 32'h0000_000C;
  localparam logic [31:0] C_OFF_STATUS = 32'h0000_0010;
  localparam logic [15:0] C_POLL_LIMIT = 16'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_RESP = 3'd2,
    S_POLL_AR = 3'd3,
    S_POLL_R  = 3'd4,
    S_RD_AR   = 3'd5,
    S_RD_R    = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t      state_q,   state_d;
  logic [1:0]  idx_q,     idx_d;
  logic [15:0] poll_q,    poll_d;
  logic [31:0] num1_q,    num1_d;
  logic [31:0] num2_q,    num2_d;
  logic [1:0]  op_q,      op_d;
  logic        busy_q,    busy_d;
  logic        done_q,    done_d;
  logic        timeout_q, timeout_d;
  logic [31:0] result_q,  result_d;
  logic [31:0] awaddr_q,  awaddr_d;
  logic        awvalid_q, awvalid_d;
  logic [31:0] wdata_q,   wdata_d;
  logic        wvalid_q,  wvalid_d;
  logic        bready_q,  bready_d;
  logic [31:0] araddr_q,  araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q,  rready_d;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic [1:0]  w_idx_next;
  logic [15:0] w_poll_inc;

  function automatic logic [31:0] wr_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    wr_addr = BASE_ADDR + C_OFF_NUM1;
      2'd1:    wr_addr = BASE_ADDR + C_OFF_NUM2;
      default: wr_addr = BASE_ADDR + C_OFF_INSTR;
    endcase
  endfunction

  function automatic logic [31:0] wr_data(input logic [1:0]  idx,
                                          input logic [31:0] n1,
                                          input logic [31:0] n2,
                                          input logic [1:0]  op);
    case (idx)
      2'd0:    wr_data = n1;
      2'd1:    wr_data = n2;
      default: wr_data = {30'b0, op};
    endcase
  endfunction

  assign w_aw_hs    = awvalid_q & axi_awready;
  assign w_w_hs     = wvalid_q & axi_wready;
  assign w_idx_next = idx_q + 2'd1;
  assign w_poll_inc = poll_q + 16'd1;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    poll_d    = poll_q;
    num1_d    = num1_q;
    num2_d    = num2_q;
    op_d      = op_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    result_d  = result_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          // The first beat uses the raw inputs since the operand flops load on this same edge.
          num1_d    = num1_in;
          num2_d    = num2_in;
          op_d      = op_in;
          idx_d     = 2'd0;
          poll_d    = 16'd0;
          busy_d    = 1'b1;
          awaddr_d  = wr_addr(2'd0);
          wdata_d   = wr_data(2'd0, num1_in, num2_in, op_in);
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_WR_ADDR;
        end
      end

      S_WR_ADDR: begin
        if (w_aw_hs) awvalid_d = 1'b0;
        if (w_w_hs)  wvalid_d  = 1'b0;
        if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (axi_bvalid) begin
          bready_d = 1'b0;
          if (idx_q == 2'd2) begin
            araddr_d  = BASE_ADDR + C_OFF_STATUS;
            arvalid_d = 1'b1;
            state_d   = S_POLL_AR;
          end else begin
            idx_d     = w_idx_next;
            awaddr_d  = wr_addr(w_idx_next);
            wdata_d   = wr_data(w_idx_next, num1_q, num2_q, op_q);
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = S_WR_ADDR;
          end
        end
      end

      S_POLL_AR: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_POLL_R;
        end
      end

      S_POLL_R: begin
        if (axi_rvalid) begin
          rready_d = 1'b0;
          if (axi_rdata[0]) begin
            araddr_d  = BASE_ADDR + C_OFF_RESULT;
            arvalid_d = 1'b1;
            state_d   = S_RD_AR;
          end else if (w_poll_inc == C_POLL_LIMIT) begin
            poll_d    = w_poll_inc;
            done_d    = 1'b1;
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            poll_d    = w_poll_inc;
            araddr_d  = BASE_ADDR + C_OFF_STATUS;
            arvalid_d = 1'b1;
            state_d   = S_POLL_AR;
          end
        end
      end

      S_RD_AR: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_R;
        end
      end

      S_RD_R: begin
        if (axi_rvalid) begin
          rready_d = 1'b0;
          result_d = axi_rdata;
          done_d   = 1'b1;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 2'd0;
      poll_q    <= 16'd0;
      num1_q    <= 32'd0;
      num2_q    <= 32'd0;
      op_q      <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      result_q  <= 32'd0;
      awaddr_q  <= 32'd0;
      awvalid_q <= 1'b0;
      wdata_q   <= 32'd0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= 32'd0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      poll_q    <= poll_d;
      num1_q    <= num1_d;
      num2_q    <= num2_d;
      op_q      <= op_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      result_q  <= result_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout     = timeout_q;
  assign result_out  = result_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign axi_araddr  = araddr_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;

endmodule
`default_nettype wire
